// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam int   CNT_W_DEF = 4;

  // Highest value reached before wrapping: MODULO-1, or all-ones for natural wrap.
  function automatic logic [31:0] calc_last(input int w, input longint m);
    logic [63:0] full;
    logic [63:0] mm;
    full = (64'd1 << w) - 64'd1;
    mm   = m - 64'd1;
    return (m != 0) ? mm[31:0] : full[31:0];
  endfunction

endpackage

// File: rtl/param_counter_next.sv
// Combinational successor/predecessor values and terminal-count decode.
module param_counter_next
  import counter_pkg::*;
#(
  parameter int     WIDTH  = CNT_W_DEF,
  parameter longint MODULO = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] next_up,
  output logic [WIDTH-1:0] next_dn,
  output logic             tc
);

  localparam logic [31:0]      LAST32 = calc_last(WIDTH, MODULO);
  localparam logic [WIDTH-1:0] LAST   = LAST32[WIDTH-1:0];

  // ">=" so an out-of-range loaded value still wraps to zero on the next up count.
  always_comb begin
    next_up = (q >= LAST) ? '0 : q + 1'b1;
    next_dn = (q == '0) ? LAST : q - 1'b1;
    tc      = (dir == DIR_UP) ? (q == LAST) : (q == '0);
  end

endmodule

// File: rtl/param_counter.sv
// Loadable, clearable, cascadable counter with optional modulus.
// Define COUNTER_DOWN_EN to add the UP_DN port and down counting.
module param_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH  = CNT_W_DEF,
  parameter longint MODULO = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             ENB_LD,
  input  logic             ENB_CNT,
  input  logic             ENB_T,
`ifdef COUNTER_DOWN_EN
  input  logic             UP_DN,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  logic             dir;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_up;
  logic [WIDTH-1:0] next_dn;
  logic             tc_w;

`ifdef COUNTER_DOWN_EN
  assign dir = UP_DN;
`else
  assign dir = DIR_UP;
`endif

  param_counter_next #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next (
    .q       (q_r),
    .dir     (dir),
    .next_up (next_up),
    .next_dn (next_dn),
    .tc      (tc_w)
  );

  // Clear beats load beats count; both clear and load ignore the enables.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  q_r <= '0;
    else if (!CLR_N)           q_r <= '0;
    else if (!ENB_LD)          q_r <= DIN;
    else if (ENB_CNT && ENB_T) q_r <= (dir == DIR_UP) ? next_up : next_dn;
  end

  assign Q  = q_r;
  assign TC = tc_w;
  assign CO = tc_w & ENB_T;

endmodule

// File: tb/tb_param_counter.sv
// Directed-vector bench: decade counter table, reset, cascade and direction sequences.
module tb_param_counter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Decade (MODULO=10) instance
  logic       rst_n = 1'b0;
  logic       d_clr = 1'b1, d_ld = 1'b1, d_cnt = 1'b0, d_t = 1'b0;
  logic [3:0] d_din = '0;
  logic [3:0] d_q;
  logic       d_tc, d_co;
`ifdef COUNTER_DOWN_EN
  logic       d_updn = 1'b1;
`endif

  param_counter #(.WIDTH(4), .MODULO(10)) u_dec (
    .CLK(CLK), .RST(rst_n), .CLR_N(d_clr), .DIN(d_din), .ENB_LD(d_ld),
    .ENB_CNT(d_cnt), .ENB_T(d_t),
`ifdef COUNTER_DOWN_EN
    .UP_DN(d_updn),
`endif
    .Q(d_q), .TC(d_tc), .CO(d_co)
  );

  // Natural-wrap instance for the asynchronous reset sequence
  logic       rst_nat = 1'b0;
  logic       n_ld = 1'b1, n_cnt = 1'b0, n_t = 1'b0;
  logic [3:0] n_din = '0;
  logic [3:0] n_q;
  logic       n_tc, n_co;

  param_counter #(.WIDTH(4), .MODULO(0)) u_nat (
    .CLK(CLK), .RST(rst_nat), .CLR_N(1'b1), .DIN(n_din), .ENB_LD(n_ld),
    .ENB_CNT(n_cnt), .ENB_T(n_t),
`ifdef COUNTER_DOWN_EN
    .UP_DN(1'b1),
`endif
    .Q(n_q), .TC(n_tc), .CO(n_co)
  );

  // Two cascaded 4-bit stages forming an 8-bit counter
  logic       c_ld = 1'b1, c_cnt = 1'b0, c_t = 1'b0;
  logic [7:0] c_din = '0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_co, hi_tc, hi_co;

  param_counter #(.WIDTH(4), .MODULO(0)) u_lo (
    .CLK(CLK), .RST(rst_n), .CLR_N(1'b1), .DIN(c_din[3:0]), .ENB_LD(c_ld),
    .ENB_CNT(c_cnt), .ENB_T(c_t),
`ifdef COUNTER_DOWN_EN
    .UP_DN(1'b1),
`endif
    .Q(lo_q), .TC(lo_tc), .CO(lo_co)
  );

  param_counter #(.WIDTH(4), .MODULO(0)) u_hi (
    .CLK(CLK), .RST(rst_n), .CLR_N(1'b1), .DIN(c_din[7:4]), .ENB_LD(c_ld),
    .ENB_CNT(c_cnt), .ENB_T(lo_co),
`ifdef COUNTER_DOWN_EN
    .UP_DN(1'b1),
`endif
    .Q(hi_q), .TC(hi_tc), .CO(hi_co)
  );

  typedef struct {
    logic       clr_n;
    logic       ld_n;
    logic [3:0] din;
    logic       cnt;
    logic       t;
    logic [3:0] q;
    logic       tc;
    logic       co;
  } vec_t;

  vec_t vecs[20];

  initial begin
    //            clr  ld    din    cnt  t     q      tc  co
    vecs[0]  = '{1'b0, 1'b0, 4'd10, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0}; // clear beats load
    vecs[1]  = '{1'b1, 1'b0, 4'd10, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0}; // load beats count
    vecs[2]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0}; // 10 is past LAST -> 0
    vecs[3]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd1,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd2,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd3,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd4,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd5,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd6,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd7,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd8,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd9,  1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 4'd9,  1'b1, 1'b0}; // ENB_T low: hold, no CO
    vecs[13] = '{1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 4'd9,  1'b1, 1'b1}; // ENB_CNT low: hold
    vecs[14] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0}; // wrap 9 -> 0
    vecs[15] = '{1'b1, 1'b0, 4'd12, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0}; // out-of-range load
    vecs[16] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 4'd8,  1'b0, 1'b1, 4'd8,  1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd9,  1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0}; // clear beats count

    // Reset state
    #12;
    d_t = 1'b1;
    #1;
    chk("rst_dec_q",  {28'd0, d_q}, 32'd0);
    chk("rst_dec_tc", {31'd0, d_tc}, 32'd0);
    chk("rst_dec_co", {31'd0, d_co}, 32'd0);
    chk("rst_nat_q",  {28'd0, n_q}, 32'd0);
    @(negedge CLK);
    rst_n   = 1'b1;
    rst_nat = 1'b1;

    // Decade table
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      d_clr = vecs[i].clr_n; d_ld = vecs[i].ld_n; d_din = vecs[i].din;
      d_cnt = vecs[i].cnt;   d_t  = vecs[i].t;
      tick();
      chk($sformatf("vec%0d_q",  i), {28'd0, d_q},  {28'd0, vecs[i].q});
      chk($sformatf("vec%0d_tc", i), {31'd0, d_tc}, {31'd0, vecs[i].tc});
      chk($sformatf("vec%0d_co", i), {31'd0, d_co}, {31'd0, vecs[i].co});
    end
    @(negedge CLK);
    d_clr = 1'b1; d_ld = 1'b1; d_cnt = 1'b0;

    // Asynchronous reset mid-count at Q=7
    n_cnt = 1'b1; n_t = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("nat_q7", {28'd0, n_q}, 32'd7);
    #2;
    rst_nat = 1'b0;
    #1;
    chk("nat_async_rst", {28'd0, n_q}, 32'd0);
    @(negedge CLK);
    rst_nat = 1'b1;
    tick();
    chk("nat_resume1", {28'd0, n_q}, 32'd1);
    tick();
    chk("nat_resume2", {28'd0, n_q}, 32'd2);
    @(negedge CLK);
    n_ld = 1'b0; n_din = 4'hF;
    tick();
    chk("nat_ld15_tc", {31'd0, n_tc}, 32'd1);
    chk("nat_ld15_co", {31'd0, n_co}, 32'd1);
    @(negedge CLK);
    n_ld = 1'b1;
    tick();
    chk("nat_wrap_q", {28'd0, n_q}, 32'd0);
    chk("nat_wrap_tc", {31'd0, n_tc}, 32'd0);

    // Cascade 8-bit counter
    @(negedge CLK);
    c_t = 1'b1; c_cnt = 1'b1; c_ld = 1'b0; c_din = 8'h0E;
    tick();
    chk("cas_ld0e", {24'd0, hi_q, lo_q}, 32'h0E);
    @(negedge CLK);
    c_ld = 1'b0 ^ 1'b1;
    tick();
    chk("cas_0f", {24'd0, hi_q, lo_q}, 32'h0F);
    chk("cas_0f_hico", {31'd0, hi_co}, 32'd0);
    tick();
    chk("cas_10", {24'd0, hi_q, lo_q}, 32'h10);
    @(negedge CLK);
    c_ld = 1'b0; c_din = 8'hFE;
    tick();
    chk("cas_fe_hico", {31'd0, hi_co}, 32'd0);
    @(negedge CLK);
    c_ld = 1'b1;
    tick();
    chk("cas_ff", {24'd0, hi_q, lo_q}, 32'hFF);
    chk("cas_ff_hico", {31'd0, hi_co}, 32'd1);
    tick();
    chk("cas_00", {24'd0, hi_q, lo_q}, 32'h00);
    chk("cas_00_hico", {31'd0, hi_co}, 32'd0);

`ifdef COUNTER_DOWN_EN
    // Down counting with a mid-sequence direction flip
    @(negedge CLK);
    d_updn = 1'b0; d_ld = 1'b0; d_din = 4'd1; d_cnt = 1'b1; d_t = 1'b1;
    tick();
    chk("dn_ld1_tc", {31'd0, d_tc}, 32'd0);
    @(negedge CLK);
    d_ld = 1'b1;
    tick();
    chk("dn_q0", {28'd0, d_q}, 32'd0);
    chk("dn_q0_tc", {31'd0, d_tc}, 32'd1);
    tick();
    chk("dn_q9", {28'd0, d_q}, 32'd9);
    tick();
    chk("dn_q8", {28'd0, d_q}, 32'd8);
    @(negedge CLK);
    d_updn = 1'b1;
    #1;
    chk("dn_flip_tc", {31'd0, d_tc}, 32'd0);
    tick();
    chk("up_q9", {28'd0, d_q}, 32'd9);
    chk("up_q9_tc", {31'd0, d_tc}, 32'd1);
    tick();
    chk("up_q0", {28'd0, d_q}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
